slurm16_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter sitting downstream of the slurm16 core's

---
 rtl/slurm16_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_slurm16_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/slurm16_uart_tx.sv
// rtl/slurm16_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Optional TX-ready interrupt output enabled by defining SLURM16_UART_TX_IRQ_EN.
module slurm16_uart_tx #(
    parameter int CLOCK_FREQ = 6000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ADDRESS,
    input  logic [15:0] DATA_IN,
    input  logic        WR,
    input  logic        RD,
    output logic [15:0] DATA_OUT,
    output logic        UART_TX
`ifdef SLURM16_UART_TX_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [15:0]     r_dout;

    logic            w_tick;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_tx;
    logic            w_push;
    logic            w_drop;
    logic            w_rd_stat;
    logic [3:0]      w_cnt4;
    logic [15:0]     w_status;
    logic            w_unused_hi;

    assign w_tick      = (r_baud == DIV_LAST);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
    assign w_wr_tx     = WR && !ADDRESS;
    // A write into a full FIFO still lands if the transmitter frees a slot this cycle
    assign w_push      = w_wr_tx && (!w_full || w_pop);
    assign w_drop      = w_wr_tx && w_full && !w_pop;
    assign w_rd_stat   = RD && ADDRESS;
    assign w_cnt4      = 4'(r_count);
    assign w_status    = {8'h00, w_cnt4, r_ovf, (r_state != S_IDLE), w_full, w_empty};
    assign w_unused_hi = ^DATA_IN[15:8];

    assign DATA_OUT = r_dout;
    assign UART_TX  = r_tx;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA_IN[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_dout   <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_rd_stat) begin
                r_ovf <= 1'b0;
            end
            if (RD) begin
                r_dout <= ADDRESS ? w_status : 16'h0000;
            end
        end
    end

    // Line flop follows the state one cycle later, keeping every bit exactly DIV cycles
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SLURM16_UART_TX_IRQ_EN
    logic r_irq;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_pop && (r_count == CW'(1)) && !w_push;
        end
    end

    assign IRQ = r_irq;
`endif

endmodule

// File: tb/tb_slurm16_uart_tx.sv
// tb/tb_slurm16_uart_tx.sv - self-checking bench for slurm16_uart_tx
// Timeline model of the FIFO and serial line, checked every cycle, plus directed literal checks.
module tb_slurm16_uart_tx;

    localparam int DIV   = 52;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * DIV;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        ADDRESS = 1'b0;
    logic [15:0] DATA_IN = 16'h0000;
    logic        WR = 1'b0;
    logic        RD = 1'b0;
    logic [15:0] DATA_OUT;
    logic        UART_TX;
`ifdef SLURM16_UART_TX_IRQ_EN
    logic        IRQ;
    int          irq_cnt = 0;
`endif

    slurm16_uart_tx #(
        .CLOCK_FREQ(6000000),
        .BAUD_RATE (115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .ADDRESS (ADDRESS),
        .DATA_IN (DATA_IN),
        .WR      (WR),
        .RD      (RD),
        .DATA_OUT(DATA_OUT),
        .UART_TX (UART_TX)
`ifdef SLURM16_UART_TX_IRQ_EN
        ,
        .IRQ     (IRQ)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the line is a function of time given the edge at which the current byte was popped
    logic [7:0]  q[$];
    bit          m_ovf;
    int          m_edge;
    int          m_free_at;
    int          m_pop_edge;
    logic [7:0]  m_cur;
    bit          m_have;
    logic [15:0] exp_dout;
    logic        exp_tx;
    int          m_cnt;
    bit          m_pop;
    bit          m_drop;
    logic [15:0] m_st;

    function automatic logic line_at(input int x);
        int k;
        if (!m_have || x < m_pop_edge + 1 || x > m_pop_edge + FRAME) return 1'b1;
        k = (x - m_pop_edge - 1) / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic busy_at(input int x);
        return m_have && (x >= m_pop_edge) && (x < m_pop_edge + FRAME);
    endfunction

    always @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            q.delete();
            m_ovf     = 1'b0;
            m_edge    = 0;
            m_free_at = 0;
            m_have    = 1'b0;
            exp_dout  = 16'h0000;
            exp_tx    = 1'b1;
        end else begin
            m_edge++;
            m_cnt = q.size();
            m_pop = (m_cnt > 0) && (m_edge >= m_free_at);
            m_st  = {8'h00, 4'(m_cnt), m_ovf, busy_at(m_edge - 1), (m_cnt == DEPTH), (m_cnt == 0)};
            if (RD) exp_dout = ADDRESS ? m_st : 16'h0000;
            if (m_pop) begin
                m_cur      = q.pop_front();
                m_pop_edge = m_edge;
                m_have     = 1'b1;
                m_free_at  = m_edge + FRAME;
            end
            m_drop = 1'b0;
            if (WR && !ADDRESS) begin
                if (m_cnt < DEPTH || m_pop) q.push_back(DATA_IN[7:0]);
                else m_drop = 1'b1;
            end
            if (RD && ADDRESS) m_ovf = m_drop;
            else if (m_drop) m_ovf = 1'b1;
            exp_tx = line_at(m_edge);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("uart_tx_vs_model", {15'b0, UART_TX}, {15'b0, exp_tx});
            check("data_out_vs_model", DATA_OUT, exp_dout);
        end
`ifdef SLURM16_UART_TX_IRQ_EN
        if (IRQ === 1'b1) irq_cnt++;
`endif
    end

    task automatic wr(input logic a, input logic [7:0] d);
        ADDRESS = a;
        DATA_IN = {8'hA5, d};
        WR      = 1'b1;
        @(negedge CLK);
        WR      = 1'b0;
        ADDRESS = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [15:0] v);
        ADDRESS = a;
        RD      = 1'b1;
        @(negedge CLK);
        RD      = 1'b0;
        ADDRESS = 1'b0;
        v       = DATA_OUT;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    logic [15:0] v;
    logic [9:0]  frame;

    initial begin
        @(negedge CLK);
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;

        // Idle after reset, register map basics
        repeat (1000) @(negedge CLK);
        rd(1'b1, v); check("status_after_reset", v, 16'h0001);
        rd(1'b0, v); check("txdata_read_zero", v, 16'h0000);
        wr(1'b1, 8'h77);
        rd(1'b1, v); check("status_write_ignored", v, 16'h0001);

        // Single byte 0x55: latency, bit width, decoded value
        wr(1'b0, 8'h55);
        check("tx_high_after_wr", {15'b0, UART_TX}, 16'h0001);
        @(negedge CLK);
        check("tx_high_wr_plus1", {15'b0, UART_TX}, 16'h0001);
        @(negedge CLK);
        for (int r = 0; r < FRAME; r++) begin
            if (r % DIV == DIV / 2) frame[r / DIV] = UART_TX;
            if (r == DIV - 1) check("start_last_cycle_low", {15'b0, UART_TX}, 16'h0000);
            if (r == DIV) check("bit0_first_cycle_high", {15'b0, UART_TX}, 16'h0001);
            @(negedge CLK);
        end
        check("start_bit", {15'b0, frame[0]}, 16'h0000);
        check("decoded_0x55", {8'h00, frame[8:1]}, 16'h0055);
        check("stop_bit", {15'b0, frame[9]}, 16'h0001);
        rd(1'b1, v); check("idle_after_frame", v, 16'h0001);

        // Ten back-to-back writes: one popped, eight queued, tenth dropped
        for (int i = 0; i < 10; i++) begin
            ADDRESS = 1'b0;
            DATA_IN = 16'(i);
            WR      = 1'b1;
            @(negedge CLK);
        end
        WR = 1'b0;
        rd(1'b1, v); check("status_full_ovf", v, 16'h008E);
        rd(1'b1, v); check("status_ovf_cleared", v, 16'h0086);
        repeat (9 * FRAME + 20) @(negedge CLK);
        rd(1'b1, v); check("status_drained", v, 16'h0001);

        // Write into full FIFO on the cycle STOP pops
        for (int i = 0; i < 9; i++) begin
            ADDRESS = 1'b0;
            DATA_IN = 16'(8'hA0 + i);
            WR      = 1'b1;
            @(negedge CLK);
        end
        WR = 1'b0;
        repeat (FRAME - 8) @(negedge CLK);
        wr(1'b0, 8'hB0);
        rd(1'b1, v); check("pop_while_push", v, 16'h0086);
        repeat (9 * FRAME + 20) @(negedge CLK);
        rd(1'b1, v); check("status_drained2", v, 16'h0001);

        // Asynchronous reset during data bit 3 of 0xF0, with bytes still queued
        wr(1'b0, 8'hF0);
        wr(1'b0, 8'h11);
        wr(1'b0, 8'h22);
        repeat (2 + 4 * DIV + 20 - 2) @(negedge CLK);
        check("tx_bit3_low", {15'b0, UART_TX}, 16'h0000);
        #2 RSTb = 1'b0;
        #1;
        check("async_reset_tx", {15'b0, UART_TX}, 16'h0001);
        check("async_reset_dout", DATA_OUT, 16'h0000);
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);
        rd(1'b1, v); check("status_after_abort", v, 16'h0001);
        repeat (2 * FRAME) @(negedge CLK);
        rd(1'b1, v); check("queue_lost_after_reset", v, 16'h0001);

`ifdef SLURM16_UART_TX_IRQ_EN
        irq_cnt = 0;
        wr(1'b0, 8'h3C);
        wr(1'b0, 8'hC3);
        repeat (2 * FRAME + 20) @(negedge CLK);
        check("irq_single_pulse", 16'(irq_cnt), 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
